// File: rtl/tft_pix_buf_pkg.sv
// Shared types and default parameters for the TFT pixel prefetch buffer.
package tft_pix_pkg;

  localparam int PIX_W = 16;

  localparam int DEF_DEPTH   = 1024;
  localparam int DEF_BURST   = 64;
  localparam int DEF_PREFILL = 256;
  localparam logic [PIX_W-1:0] DEF_UNDERRUN_PIX = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    PREFETCH,
    RUN
  } pix_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous FIFO with a registered show-ahead head; head reads EMPTY_VAL
// whenever the FIFO holds no data.
module sync_fifo_fwft
  import tft_pix_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = 10,
  parameter logic [PIX_W-1:0] EMPTY_VAL = DEF_UNDERRUN_PIX
) (
  input  logic             clk_33m,
  input  logic             sys_rst_n,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [PIX_W-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [PIX_W-1:0] head_o,
  output logic [AW:0]      level_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [AW:0]      level_q, level_d;
  logic [PIX_W-1:0] head_q, head_d;
  logic             push, pop;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign push    = wr_en_i & ~full_o & ~flush_i;
  assign pop     = rd_en_i & ~empty_o & ~flush_i;
  assign rd_nxt  = rd_ptr_q + AW'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = head_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      head_d   = EMPTY_VAL;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_nxt;
      level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
      // Last word leaving: only a same-cycle push can refill the head slot.
      if (pop) begin
        if (level_q == ONE_LVL) head_d = push ? wr_data_i : EMPTY_VAL;
        else                    head_d = mem[rd_nxt];
      end else if (push && empty_o) begin
        head_d = wr_data_i;
      end
    end
  end

  always_ff @(posedge clk_33m) begin
    if (push) mem[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_33m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= EMPTY_VAL;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  assign head_o  = head_q;
  assign level_o = level_q;

endmodule

// File: rtl/tft_pix_buf.sv
// Pixel prefetch buffer feeding the TFT timing generator; burst request
// control and frame re-alignment. TFT_PIX_BUF_STAT_EN adds underrun counters.
//   state    | meaning
//   IDLE     | after reset, waiting for first vsync rise
//   FLUSH    | one cycle: frame_start, buffer and burst accounting cleared
//   PREFETCH | requesting bursts until PREFILL pixels stored
//   RUN      | streaming, ready high
module tft_pix_buf
  import tft_pix_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = 10,
  parameter int BURST   = DEF_BURST,
  parameter int PREFILL = DEF_PREFILL,
  parameter logic [PIX_W-1:0] UNDERRUN_PIX = DEF_UNDERRUN_PIX
) (
  input  logic             clk_33m,
  input  logic             sys_rst_n,
  input  logic             vsync,
  input  logic             data_req,
  output logic [PIX_W-1:0] data_out,
  input  logic             wr_en,
  input  logic [PIX_W-1:0] wr_data,
  output logic             rd_req,
  input  logic             rd_ack,
  output logic             frame_start,
  output logic [AW:0]      fill_level,
  output logic             ready,
  output logic             underrun,
  output logic             overflow
`ifdef TFT_PIX_BUF_STAT_EN
  ,
  output logic [15:0]      underrun_cnt,
  output logic [15:0]      last_underrun_cnt
`endif
);

  localparam logic [AW:0]   BURST_L   = (AW+1)'(BURST);
  localparam logic [AW:0]   PREFILL_L = (AW+1)'(PREFILL);
  localparam logic [AW+1:0] REQ_LIM   = (AW+2)'(DEPTH - BURST);

  pix_state_e  state_q, state_d;
  logic        vsync_q, vs_rise, go_flush;
  logic        wr_ok, push_acc, ack_acc, req_room, full, empty;
  logic        rd_req_q, rd_req_d, underrun_q, underrun_d, overflow_q, overflow_d;
  logic [AW:0] outst_q, outst_d, outst_add;

  assign vs_rise  = vsync & ~vsync_q;
  assign go_flush = vs_rise & (state_q != FLUSH);
  assign wr_ok    = wr_en & (state_q != FLUSH) & ~go_flush;
  assign push_acc = wr_ok & ~full;
  assign ack_acc  = rd_req_q & rd_ack;
  assign req_room = ({1'b0, fill_level} + {1'b0, outst_q}) <= REQ_LIM;

  sync_fifo_fwft #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .EMPTY_VAL (UNDERRUN_PIX)
  ) u_fifo (
    .clk_33m   (clk_33m),
    .sys_rst_n (sys_rst_n),
    .flush_i   (go_flush),
    .wr_en_i   (wr_ok),
    .wr_data_i (wr_data),
    .rd_en_i   (data_req),
    .head_o    (data_out),
    .level_o   (fill_level),
    .full_o    (full),
    .empty_o   (empty)
  );

  always_comb begin
    state_d    = state_q;
    rd_req_d   = rd_req_q;
    outst_add  = outst_q;
    outst_d    = outst_q;
    underrun_d = underrun_q;
    overflow_d = overflow_q;
    if (go_flush) begin
      state_d    = FLUSH;
      rd_req_d   = 1'b0;
      outst_d    = '0;
      underrun_d = 1'b0;
    end else begin
      case (state_q)
        FLUSH:    state_d = PREFETCH;
        PREFETCH: if (fill_level >= PREFILL_L) state_d = RUN;
        default:  state_d = state_q;
      endcase
      outst_add = ack_acc ? outst_q + BURST_L : outst_q;
      outst_d   = (push_acc && outst_add != '0) ? outst_add - (AW+1)'(1) : outst_add;
      // Looking at state_d lets the first request rise right after FLUSH.
      if (ack_acc) begin
        rd_req_d = 1'b0;
      end else if (!rd_req_q && req_room &&
                   (state_d == PREFETCH || state_d == RUN)) begin
        rd_req_d = 1'b1;
      end
      if (data_req && empty) underrun_d = 1'b1;
      if (wr_ok && full)     overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_33m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      vsync_q    <= 1'b0;
      rd_req_q   <= 1'b0;
      outst_q    <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= vsync;
      rd_req_q   <= rd_req_d;
      outst_q    <= outst_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  assign rd_req      = rd_req_q;
  assign frame_start = (state_q == FLUSH);
  assign ready       = (state_q == RUN);
  assign underrun    = underrun_q;
  assign overflow    = overflow_q;

`ifdef TFT_PIX_BUF_STAT_EN
  logic [15:0] ucnt_q, last_ucnt_q;

  always_ff @(posedge clk_33m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ucnt_q      <= '0;
      last_ucnt_q <= '0;
    end else if (go_flush) begin
      last_ucnt_q <= ucnt_q;
      ucnt_q      <= '0;
    end else if (data_req && empty && ucnt_q != 16'hFFFF) begin
      ucnt_q <= ucnt_q + 16'd1;
    end
  end

  assign underrun_cnt      = ucnt_q;
  assign last_underrun_cnt = last_ucnt_q;
`endif

endmodule

// File: tb/tb_tft_pix_buf.sv
// Directed bench for tft_pix_buf: prefetch, streaming, starvation, overflow
// and mid-burst frame re-alignment. Optionally built with TFT_PIX_BUF_STAT_EN.
module tb_tft_pix_buf;

  logic        clk_33m = 1'b0;
  logic        sys_rst_n;
  logic        vsync, data_req, wr_en, rd_ack;
  logic [15:0] wr_data;
  logic [15:0] data_out;
  logic        rd_req, frame_start, ready, underrun, overflow;
  logic [10:0] fill_level;
`ifdef TFT_PIX_BUF_STAT_EN
  logic [15:0] underrun_cnt, last_underrun_cnt;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          burst_left = 0;
  int          n_starve = 0;
  logic [15:0] wr_val = 16'h1000;
  logic [15:0] exp_q[$];

  always #15 clk_33m = ~clk_33m;

  tft_pix_buf dut (
    .clk_33m     (clk_33m),
    .sys_rst_n   (sys_rst_n),
    .vsync       (vsync),
    .data_req    (data_req),
    .data_out    (data_out),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_req      (rd_req),
    .rd_ack      (rd_ack),
    .frame_start (frame_start),
    .fill_level  (fill_level),
    .ready       (ready),
    .underrun    (underrun),
    .overflow    (overflow)
`ifdef TFT_PIX_BUF_STAT_EN
    ,
    .underrun_cnt      (underrun_cnt),
    .last_underrun_cnt (last_underrun_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge. Models the reader
  // (one burst per ack) and the expected FIFO contents.
  task automatic cyc(input bit allow_ack, input bit req, input bit force_wr);
    int lvl_pre;
    lvl_pre = exp_q.size();
    chk("level", 32'(fill_level), lvl_pre);
    data_req = req;
    if (req) begin
      if (lvl_pre > 0) begin
        chk("pix", 32'(data_out), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end else begin
        chk("upix", 32'(data_out), 32'h0000);
        n_starve++;
      end
    end
    rd_ack = 1'b0;
    wr_en  = 1'b0;
    if (burst_left > 0 || force_wr) begin
      wr_en   = 1'b1;
      wr_data = wr_val;
      if (lvl_pre < 1024) exp_q.push_back(wr_val);
      wr_val++;
      if (burst_left > 0) burst_left--;
    end else if (allow_ack && rd_req) begin
      rd_ack     = 1'b1;
      burst_left = 64;
    end
    @(negedge clk_33m);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    vsync     = 1'b0;
    data_req  = 1'b1;
    wr_en     = 1'b0;
    wr_data   = '0;
    rd_ack    = 1'b0;
    #40;
    chk("rst_dout",  32'(data_out), 32'h0000);
    chk("rst_rdreq", 32'(rd_req), 0);
    chk("rst_level", 32'(fill_level), 0);
    chk("rst_unr",   32'(underrun), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_ovf",   32'(overflow), 0);
`ifdef TFT_PIX_BUF_STAT_EN
    chk("rst_ucnt",  32'(underrun_cnt), 0);
`endif
    @(negedge clk_33m);
    sys_rst_n = 1'b1;
    data_req  = 1'b0;
    @(negedge clk_33m);
    repeat (2) cyc(0, 0, 0);
    chk("idle_rdreq", 32'(rd_req), 0);

    // First frame: flush, first request, first burst.
    chk("fs_pre", 32'(frame_start), 0);
    vsync = 1'b1;
    @(negedge clk_33m);
    chk("fs_hi", 32'(frame_start), 1);
    chk("flush_rdreq", 32'(rd_req), 0);
    @(negedge clk_33m);
    chk("fs_lo", 32'(frame_start), 0);
    chk("req_after_flush", 32'(rd_req), 1);
    vsync = 1'b0;
    n_starve = 0;
    cyc(1, 0, 0);
    chk("req_drop", 32'(rd_req), 0);
    repeat (64) cyc(0, 0, 0);
    chk("lvl64", 32'(fill_level), 64);
    chk("req_again", 32'(rd_req), 1);
    chk("rdy_pre", 32'(ready), 0);

    for (int k = 0; k < 2000 && fill_level < 11'd256; k++) cyc(1, 0, 0);
    chk("lvl_prefill", 32'(fill_level), 256);
    chk("rdy_at_prefill", 32'(ready), 0);
    cyc(1, 0, 0);
    chk("rdy_run", 32'(ready), 1);

    // Streaming with the reader keeping pace.
    repeat (640) cyc(1, 1, 0);
    chk("run_unr", 32'(underrun), 0);
    chk("run_ovf", 32'(overflow), 0);

    // Stop acking and drain until starved.
    for (int k = 0; k < 3000 && (exp_q.size() > 0 || burst_left > 0); k++) cyc(0, 1, 0);
    chk("unr_before_starve", 32'(underrun), 0);
    repeat (5) cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("unr_starve", 32'(underrun), 1);
`ifdef TFT_PIX_BUF_STAT_EN
    chk("ucnt_starve", 32'(underrun_cnt), n_starve);
`endif

    // Overflow: 1025 writes with no ack and no reads.
    wr_val = 16'h2000;
    repeat (1024) cyc(0, 0, 1);
    chk("lvl_full", 32'(fill_level), 1024);
    chk("ovf_pre", 32'(overflow), 0);
    cyc(0, 0, 1);
    chk("lvl_ovf", 32'(fill_level), 1024);
    chk("ovf_set", 32'(overflow), 1);
    chk("head_ovf", 32'(data_out), 32'h2000);
    for (int k = 0; k < 1100 && exp_q.size() > 0; k++) cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("ovf_sticky", 32'(overflow), 1);

    // vsync rise with 30 words of a burst still outstanding.
    cyc(1, 0, 0);
    repeat (34) cyc(0, 0, 0);
    chk("lvl34", 32'(fill_level), 34);
    chk("unr_before_flush", 32'(underrun), 1);
    burst_left = 0;
    exp_q.delete();
    vsync   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 16'hBEEF;
    @(negedge clk_33m);
    chk("fs2_hi", 32'(frame_start), 1);
    chk("fs2_level", 32'(fill_level), 0);
    chk("fs2_rdreq", 32'(rd_req), 0);
    chk("fs2_unr", 32'(underrun), 0);
    chk("fs2_ready", 32'(ready), 0);
`ifdef TFT_PIX_BUF_STAT_EN
    chk("fs2_ucnt", 32'(underrun_cnt), 0);
    chk("fs2_last", 32'(last_underrun_cnt), n_starve);
`endif
    n_starve = 0;
    wr_en   = 1'b1;
    wr_data = 16'hDEAD;
    @(negedge clk_33m);
    wr_en = 1'b0;
    vsync = 1'b0;
    chk("fs2_lo", 32'(frame_start), 0);
    chk("post_flush_level", 32'(fill_level), 0);
    chk("post_flush_rdreq", 32'(rd_req), 1);
    chk("post_flush_dout", 32'(data_out), 32'h0000);
    cyc(0, 0, 0);
    chk("post_flush_ovf", 32'(overflow), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
